cl_ocl_axil_mstr: RTL

//  Single-outstanding AXI4-Lite master (initiator) for the CL. Turns a simple

---
 rtl/cl_ocl_axil_mstr.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cl_ocl_axil_mstr.sv
// Single-outstanding AXI4-Lite master for the CL.
// A command/response handshake becomes one AXI-L write (AW+W->B) or read
// (AR->R). A watchdog reports a hung slave with a synthetic response while
// the bus side keeps obeying AXI and silently absorbs the late B/R.
module cl_ocl_axil_mstr #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [1:0]  TO_RESP        = 2'b10
) (
    input  logic        clk_main_a0,
    input  logic        rst_main,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RD   = 3'd3,
        ST_RR   = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic        TO_EN  = (TIMEOUT_CYCLES != 0);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic [15:0] cnt_r;
    logic        to_r;        // watchdog response already issued for this command
    logic        rsp_done_r;  // watchdog response already consumed
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic [1:0]  rsp_resp_r;
    logic        rsp_timeout_r;

    logic accept_s, aw_hs_s, w_hs_s, b_hs_s, r_hs_s, rsp_hs_s, bus_st_s, to_fire_s;

    assign cmd_ready     = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign m_axi_awaddr  = addr_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_awvalid = (state_r == ST_WR) && !aw_done_r;
    assign m_axi_wvalid  = (state_r == ST_WR) && !w_done_r;
    assign m_axi_bready  = (state_r == ST_WB);
    assign m_axi_arvalid = (state_r == ST_RD);
    assign m_axi_rready  = (state_r == ST_RR);
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_timeout   = rsp_timeout_r;

    assign accept_s = cmd_ready && cmd_valid;
    assign aw_hs_s  = m_axi_awvalid && m_axi_awready;
    assign w_hs_s   = m_axi_wvalid && m_axi_wready;
    assign b_hs_s   = m_axi_bready && m_axi_bvalid;
    assign r_hs_s   = m_axi_rready && m_axi_rvalid;
    assign rsp_hs_s = rsp_valid_r && rsp_ready;
    assign bus_st_s = (state_r == ST_WR) || (state_r == ST_WB) ||
                      (state_r == ST_RD) || (state_r == ST_RR);
    // A bus response in the same cycle always beats the watchdog.
    assign to_fire_s = TO_EN && bus_st_s && !to_r && !b_hs_s && !r_hs_s &&
                       (cnt_r == (TO_LIM - 16'd1));

    // State register.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; after a watchdog response, a late B/R ends the command
    // directly once that response has been (or is being) consumed.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = cmd_wr ? ST_WR : ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if ((aw_done_r || m_axi_awready) && (w_done_r || m_axi_wready)) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_RD: begin
                if (m_axi_arready) begin
                    state_nxt_s = ST_RR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_WB, ST_RR: begin
                if (b_hs_s || r_hs_s) begin
                    if (to_r && (rsp_done_r || rsp_hs_s)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RSP;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RSP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command capture, per-channel handshake tracking and watchdog counter.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            cnt_r      <= 16'd0;
            to_r       <= 1'b0;
            rsp_done_r <= 1'b0;
        end else if (accept_s) begin
            addr_r     <= cmd_addr;
            wdata_r    <= cmd_wdata;
            wstrb_r    <= cmd_wstrb;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            cnt_r      <= 16'd0;
            to_r       <= 1'b0;
            rsp_done_r <= 1'b0;
        end else begin
            if (aw_hs_s) aw_done_r <= 1'b1;
            if (w_hs_s)  w_done_r  <= 1'b1;
            if (bus_st_s && (cnt_r != 16'hFFFF) && !(TO_EN && (cnt_r == TO_LIM))) begin
                cnt_r <= cnt_r + 16'd1;
            end
            if (to_fire_s) to_r <= 1'b1;
            if (rsp_hs_s && to_r) rsp_done_r <= 1'b1;
        end
    end

    // Response register: bus response, watchdog response, or hold until consumed.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'd0;
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
        end else if (b_hs_s && !to_r) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= 32'd0;
            rsp_resp_r    <= m_axi_bresp;
            rsp_timeout_r <= 1'b0;
        end else if (r_hs_s && !to_r) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= m_axi_rdata;
            rsp_resp_r    <= m_axi_rresp;
            rsp_timeout_r <= 1'b0;
        end else if (to_fire_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= 32'd0;
            rsp_resp_r    <= TO_RESP;
            rsp_timeout_r <= 1'b1;
        end else if (rsp_hs_s) begin
            rsp_valid_r   <= 1'b0;
        end
    end

endmodule
